// File: rtl/mem_bus_master.sv
// Initiator-side controller for the banked single-port synchronous RAM bus.
// Takes single-word or burst commands, sequences cs/we/oe, owns the data bus
// during write pulses and returns read words on a valid/ready stream.
module mem_bus_master #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_WAIT    = 3'd1,
    S_WR_PULSE   = 3'd2,
    S_RD_ISSUE   = 3'd3,
    S_RD_CAPTURE = 3'd4,
    S_RD_HOLD    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] wbuf_q, wbuf_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Next-state and datapath updates for the burst sequencer.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    wbuf_d      = wbuf_q;
    rd_data_d   = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          state_d     = cmd_we ? S_WR_WAIT : S_RD_ISSUE;
        end
      end
      S_WR_WAIT: begin
        if (wr_valid) begin
          wbuf_d  = wr_data;
          state_d = S_WR_PULSE;
        end
      end
      S_WR_PULSE: begin
        if (remaining_q == LEN_WIDTH'(0)) begin
          state_d = S_IDLE;
        end else begin
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          state_d     = S_WR_WAIT;
        end
      end
      S_RD_ISSUE: begin
        state_d = S_RD_CAPTURE;
      end
      S_RD_CAPTURE: begin
        rd_data_d = mem_data;
        state_d   = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (rd_ready) begin
          if (remaining_q == LEN_WIDTH'(0)) begin
            state_d = S_IDLE;
          end else begin
            cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - LEN_WIDTH'(1);
            state_d     = S_RD_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      wbuf_q      <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      wbuf_q      <= wbuf_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Pin decode from the registered state only, so reset releases the bus at once.
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign wr_ready  = (state_q == S_WR_WAIT);
  assign rd_valid  = (state_q == S_RD_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign rd_data   = rd_data_q;
  assign mem_addr  = cur_addr_q;
  assign mem_cs    = (state_q == S_WR_PULSE) || (state_q == S_RD_ISSUE) ||
                     (state_q == S_RD_CAPTURE);
  assign mem_we    = (state_q == S_WR_PULSE);
  assign mem_oe    = (state_q == S_RD_ISSUE) || (state_q == S_RD_CAPTURE);

  // Master drives the data bus only during a write pulse.
  assign mem_data  = (state_q == S_WR_PULSE) ? wbuf_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Randomized self-checking bench for mem_bus_master with a behavioural RAM
// on the bus and an address-indexed reference memory in the bench.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_data;
  logic        busy;
  logic [15:0] mem_addr;
  wire  [15:0] mem_data;
  logic        mem_cs, mem_we, mem_oe;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .LEN_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM: registers the read word, drives it while cs&oe.
  logic [15:0] ram [0:65535];
  logic [15:0] ram_dout;
  logic        ram_drive;
  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    else if (mem_cs && mem_oe) ram_dout <= ram[mem_addr];
  end
  assign ram_drive = mem_cs && mem_oe && !mem_we;
  assign mem_data  = ram_drive ? ram_dout : 16'bz;

  // Probe driver on idle pins: any master drive would corrupt the probe value.
  logic        probe_tog = 1'b0;
  logic        probe_en;
  logic [15:0] probe_val;
  always @(posedge clk) probe_tog <= ~probe_tog;
  assign probe_en  = !mem_cs && !mem_we && !mem_oe;
  assign probe_val = probe_tog ? 16'h5A5A : 16'h0000;
  assign mem_data  = probe_en ? probe_val : 16'bz;

  // Reference model: expected memory contents and expected write pulses.
  logic [15:0] model_mem [int];
  typedef struct { logic [15:0] a; logic [15:0] d; } pulse_t;
  pulse_t exp_pulses[$];

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'h0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle bus ownership and write-pulse monitor.
  always @(negedge clk) begin
    check_eq("we_and_oe", 32'(mem_we && mem_oe), 0);
    if (probe_en) check_eq("bus_owner", 32'(mem_data), 32'(probe_val));
    if (mem_cs && mem_we) begin
      if (exp_pulses.size() == 0) begin
        check_eq("pulse_unexpected", 1, 0);
      end else begin
        pulse_t p;
        p = exp_pulses.pop_front();
        check_eq("pulse_addr", 32'(mem_addr), 32'(p.a));
        check_eq("pulse_data", 32'(mem_data), 32'(p.d));
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [15:0] addr, input logic [3:0] len);
    int n;
    cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check_eq("cmd_accept", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [3:0] len,
                          input logic [15:0] data [16], input int gap);
    int n;
    logic [15:0] a;
    send_cmd(1'b1, addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 16'(i);
      model_mem[int'(a)] = data[i];
      exp_pulses.push_back('{a, data[i]});
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          check_eq("busy_in_gap", 32'(busy), 1);
          check_eq("cmd_ready_busy", 32'(cmd_ready), 0);
        end
      end
      wr_data = data[i]; wr_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wr_ready && n < 50) begin @(negedge clk); n++; end
      check_eq("wr_ready", 32'(wr_ready), 1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      wr_data  = 16'($urandom);
    end
    @(posedge clk); #1;
    check_eq("wr_done_busy", 32'(busy), 0);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [3:0] len,
                         input int stall_word, input int stall_cycles);
    int n;
    logic [15:0] exp;
    send_cmd(1'b0, addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      exp = model_rd(addr + 16'(i));
      n = 0;
      while (!rd_valid && n < 20) begin @(posedge clk); #1; n++; end
      check_eq("rd_latency", 32'(n), 2);
      check_eq("rd_valid", 32'(rd_valid), 1);
      check_eq("rd_data", 32'(rd_data), 32'(exp));
      if (i == stall_word) begin
        for (int s = 0; s < stall_cycles; s++) begin
          @(posedge clk); #1;
          check_eq("stall_valid", 32'(rd_valid), 1);
          check_eq("stall_data", 32'(rd_data), 32'(exp));
          check_eq("stall_cs", 32'(mem_cs), 0);
        end
      end
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
    end
    check_eq("rd_done_busy", 32'(busy), 0);
    check_eq("rd_done_ready", 32'(cmd_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    logic [15:0] wd [16];
    logic [15:0] ra;
    logic [3:0]  rl;
    for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    #1;
    check_eq("rst_cs", 32'(mem_cs), 0);
    check_eq("rst_we", 32'(mem_we), 0);
    check_eq("rst_oe", 32'(mem_oe), 0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
    check_eq("rst_wr_ready", 32'(wr_ready), 0);
    check_eq("rst_rd_valid", 32'(rd_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_rd_data", 32'(rd_data), 0);
    check_eq("rst_addr", 32'(mem_addr), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_eq("post_rst_ready", 32'(cmd_ready), 1);

    // Single write then read.
    wd[0] = 16'h1234;
    do_write(16'h0010, 4'd0, wd, 0);
    do_read(16'h0010, 4'd0, -1, 0);

    // Burst write with gaps across a bank boundary, then read back.
    for (int i = 0; i < 4; i++) wd[i] = 16'hA0A0 + 16'(i * 16'h0101);
    do_write(16'h3FFE, 4'd3, wd, 2);
    do_read(16'h3FFE, 4'd3, -1, 0);

    // Read backpressure on word 2.
    do_read(16'h3FFE, 4'd3, 2, 5);

    // Address wrap.
    wd[0] = 16'hBEEF; wd[1] = 16'hCAFE;
    do_write(16'hFFFF, 4'd1, wd, 1);
    do_read(16'hFFFF, 4'd0, -1, 0);
    do_read(16'h0000, 4'd0, -1, 0);

    // Asynchronous reset during RD_CAPTURE of a read burst.
    send_cmd(1'b0, 16'h3FFE, 4'd3);
    @(posedge clk); #1;
    check_eq("pre_rst_cs", 32'(mem_cs), 1);
    check_eq("pre_rst_oe", 32'(mem_oe), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_cs", 32'(mem_cs), 0);
    check_eq("arst_oe", 32'(mem_oe), 0);
    check_eq("arst_rd_valid", 32'(rd_valid), 0);
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_cmd_ready", 32'(cmd_ready), 0);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check_eq("rel_cmd_ready", 32'(cmd_ready), 1);
    check_eq("rel_busy", 32'(busy), 0);
    check_eq("rel_rd_data", 32'(rd_data), 0);
    do_read(16'h3FFE, 4'd3, 0, 1);

    // Randomized command mix around the wrap and bank boundaries.
    for (int k = 0; k < 30; k++) begin
      ra = (k % 2 == 0 ? 16'hFFF8 : 16'h3FF8) + 16'($urandom_range(0, 15));
      rl = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) wd[i] = 16'($urandom);
        do_write(ra, rl, wd, int'($urandom_range(0, 2)));
      end else begin
        do_read(ra, rl, int'($urandom_range(0, int'(rl))), int'($urandom_range(0, 3)));
      end
    end

    check_eq("pulses_left", 32'(exp_pulses.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
